halt_ctrl: RTL and testbench

Parametrised halt controller for the single-cycle core; next generation of the end-of-program halt detector. Latches an end PC on a start pulse, then halts the core on end-PC match, on any of `NUM_BP` programmable breakpoints, or on a cycle-count timeout. It reports the cause and supports resume-from-breakpoint. Sits beside the PC register; `halt` gates PC update and the testbench done check.

---
 rtl/halt_pkg.sv | 18 +
 rtl/halt_bp_match.sv | 58 +++++
 rtl/halt_ctrl.sv | 130 +++++++++++++
 tb/tb_halt_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_pkg.sv
// Shared types for the halt controller: FSM states and halt-cause encodings.
package halt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2,
    ST_DONE  = 2'd3
  } halt_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_END     = 2'd1,
    CAUSE_BP      = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/halt_bp_match.sv
// Breakpoint slot storage plus PC comparators and a lowest-index-wins priority encoder.
module halt_bp_match #(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 4,
  parameter int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bp_wr_en,
  input  logic [IDX_W-1:0] bp_wr_idx,
  input  logic [PC_W-1:0]  bp_wr_addr,
  input  logic             bp_wr_valid,
  input  logic [PC_W-1:0]  pc_curr,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  logic [PC_W-1:0]   r_addr [NUM_BP];
  logic [NUM_BP-1:0] r_valid;
  logic [NUM_BP-1:0] w_match;

  // Indices at or above NUM_BP match no slot, so such writes fall through.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        r_addr[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else if (bp_wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr_idx == IDX_W'(i)) begin
          r_addr[i]  <= bp_wr_addr;
          r_valid[i] <= bp_wr_valid;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_cmp
      assign w_match[gi] = r_valid[gi] && (r_addr[gi] == pc_curr);
    end
  endgenerate

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Halt controller: stops the core on end-PC match, breakpoint or cycle timeout,
// reports the cause, and supports resume-from-breakpoint.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 4,
  parameter int CYC_W  = 16,
  parameter int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc_curr,
  input  logic [PC_W-1:0]  pc_end,
  input  logic             start,
  input  logic             resume,
  input  logic             bp_wr_en,
  input  logic [IDX_W-1:0] bp_wr_idx,
  input  logic [PC_W-1:0]  bp_wr_addr,
  input  logic             bp_wr_valid,
  input  logic [CYC_W-1:0] timeout_limit,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [IDX_W-1:0] bp_hit_idx,
  output logic [CYC_W-1:0] cycle_count
);

  halt_state_e      r_state, w_state_next;
  halt_cause_e      r_cause, w_cause_next, w_run_cause;
  logic [PC_W-1:0]  r_end_pc, w_end_pc_next;
  logic [CYC_W-1:0] r_cycle, w_cycle_next;
  logic [IDX_W-1:0] r_bp_idx, w_bp_idx_next;
  logic             r_bp_sup, w_bp_sup_next;

  logic             w_bp_hit;
  logic [IDX_W-1:0] w_bp_idx;
  logic             w_end_match, w_bp_match, w_to_match, w_any_match;

  halt_bp_match #(
    .PC_W  (PC_W),
    .NUM_BP(NUM_BP),
    .IDX_W (IDX_W)
  ) u_bp (
    .clk        (clk),
    .reset      (reset),
    .bp_wr_en   (bp_wr_en),
    .bp_wr_idx  (bp_wr_idx),
    .bp_wr_addr (bp_wr_addr),
    .bp_wr_valid(bp_wr_valid),
    .pc_curr    (pc_curr),
    .hit        (w_bp_hit),
    .hit_idx    (w_bp_idx)
  );

  assign w_end_match = (pc_curr == r_end_pc);
  assign w_bp_match  = w_bp_hit && !r_bp_sup;
  assign w_to_match  = (timeout_limit != '0) && (r_cycle == timeout_limit);
  assign w_any_match = w_end_match || w_bp_match || w_to_match;

  always_comb begin
    w_run_cause = CAUSE_NONE;
    if (w_end_match)     w_run_cause = CAUSE_END;
    else if (w_bp_match) w_run_cause = CAUSE_BP;
    else if (w_to_match) w_run_cause = CAUSE_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cause  <= CAUSE_NONE;
      r_end_pc <= '0;
      r_cycle  <= '0;
      r_bp_idx <= '0;
      r_bp_sup <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cause  <= w_cause_next;
      r_end_pc <= w_end_pc_next;
      r_cycle  <= w_cycle_next;
      r_bp_idx <= w_bp_idx_next;
      r_bp_sup <= w_bp_sup_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cause_next  = r_cause;
    w_end_pc_next = r_end_pc;
    w_cycle_next  = r_cycle;
    w_bp_idx_next = r_bp_idx;
    w_bp_sup_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next  = ST_RUN;
          w_end_pc_next = pc_end;
          w_cycle_next  = '0;
          w_cause_next  = CAUSE_NONE;
        end
      end
      ST_RUN: begin
        if (w_any_match) begin
          w_cause_next = w_run_cause;
          if (w_run_cause == CAUSE_BP) begin
            w_state_next  = ST_BREAK;
            w_bp_idx_next = w_bp_idx;
          end else begin
            w_state_next = ST_DONE;
          end
        end else if (r_cycle != '1) begin
          w_cycle_next = r_cycle + 1'b1;
        end
      end
      ST_BREAK: begin
        if (resume) begin
          w_state_next  = ST_RUN;
          w_bp_sup_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outside RUN the outputs reflect the latched halt; inside RUN they track the live match.
  assign halt        = (r_state != ST_RUN) || w_any_match;
  assign halt_cause  = (r_state == ST_RUN) ? w_run_cause : r_cause;
  assign bp_hit_idx  = (r_state == ST_RUN && w_run_cause == CAUSE_BP) ? w_bp_idx : r_bp_idx;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: a default instance plus a 5-slot, 4-bit-counter
// instance for out-of-range slot writes and counter saturation.
module tb_halt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_curr, pc_end, bp_wr_addr;
  logic       start, resume, bp_wr_en, bp_wr_valid;
  logic [1:0] bp_wr_idx;
  logic [15:0] timeout_limit;
  logic       halt;
  logic [1:0] halt_cause, bp_hit_idx;
  logic [15:0] cycle_count;

  logic       bp_wr_en5;
  logic [2:0] bp_wr_idx5;
  logic [3:0] timeout_limit5;
  logic       halt5;
  logic [1:0] halt_cause5;
  logic [2:0] bp_hit_idx5;
  logic [3:0] cycle_count5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  halt_ctrl #(.PC_W(8), .NUM_BP(4), .CYC_W(16)) u_dut (
    .clk(clk), .reset(reset), .pc_curr(pc_curr), .pc_end(pc_end),
    .start(start), .resume(resume), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .timeout_limit(timeout_limit),
    .halt(halt), .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count)
  );

  halt_ctrl #(.PC_W(8), .NUM_BP(5), .CYC_W(4)) u_dut5 (
    .clk(clk), .reset(reset), .pc_curr(pc_curr), .pc_end(pc_end),
    .start(start), .resume(resume), .bp_wr_en(bp_wr_en5), .bp_wr_idx(bp_wr_idx5),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .timeout_limit(timeout_limit5),
    .halt(halt5), .halt_cause(halt_cause5), .bp_hit_idx(bp_hit_idx5), .cycle_count(cycle_count5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_curr = '0; pc_end = '0; start = 1'b0; resume = 1'b0;
    bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 1'b0;
    timeout_limit = '0; bp_wr_en5 = 1'b0; bp_wr_idx5 = '0; timeout_limit5 = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    sample();
    check("rst_halt", 32'(halt), 32'd1);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_bpidx", 32'(bp_hit_idx), 32'd0);
    check("rst_cycle", 32'(cycle_count), 32'd0);

    // End-PC sweep
    pc_end = 8'h20; start = 1'b1; pc_curr = 8'h00;
    tick();
    start = 1'b0;
    for (int p = 0; p < 32; p++) begin
      pc_curr = 8'(p);
      sample();
      check("sweep_halt", 32'(halt), 32'd0);
      check("sweep_cycle", 32'(cycle_count), 32'(p));
      if (p == 31) check("sat5_nohalt", 32'(halt5), 32'd0);
      tick();
    end
    pc_curr = 8'h20;
    sample();
    check("end_halt", 32'(halt), 32'd1);
    check("end_cause", 32'(halt_cause), 32'd1);
    check("end_cycle", 32'(cycle_count), 32'h20);
    tick();
    pc_curr = 8'h00;
    sample();
    check("done_halt", 32'(halt), 32'd1);
    check("done_cause", 32'(halt_cause), 32'd1);
    check("done_cycle", 32'(cycle_count), 32'h20);
    check("sat5_cycle", 32'(cycle_count5), 32'hF);
    check("sat5_cause", 32'(halt_cause5), 32'd1);

    // Breakpoints: slots 2 and 0 both at 0x10, lowest index wins
    bp_wr_en = 1'b1; bp_wr_valid = 1'b1; bp_wr_addr = 8'h10; bp_wr_idx = 2'd2;
    tick();
    bp_wr_idx = 2'd0;
    tick();
    bp_wr_en = 1'b0;
    pc_end = 8'h30; start = 1'b1; pc_curr = 8'h0E;
    tick();
    start = 1'b0;
    sample();
    check("bp_pre_halt", 32'(halt), 32'd0);
    tick();
    pc_curr = 8'h0F;
    tick();
    pc_curr = 8'h10;
    sample();
    check("bp_halt", 32'(halt), 32'd1);
    check("bp_cause", 32'(halt_cause), 32'd2);
    check("bp_idx", 32'(bp_hit_idx), 32'd0);
    tick();
    sample();
    check("brk_halt", 32'(halt), 32'd1);
    check("brk_cause", 32'(halt_cause), 32'd2);
    check("brk_cycle", 32'(cycle_count), 32'd2);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    sample();
    check("resume_sup_halt", 32'(halt), 32'd0);
    check("resume_sup_cause", 32'(halt_cause), 32'd0);
    tick();
    pc_curr = 8'h11;
    sample();
    check("resume_run_halt", 32'(halt), 32'd0);
    check("resume_run_cycle", 32'(cycle_count), 32'd3);
    tick();
    pc_curr = 8'h10;
    sample();
    check("refire_halt", 32'(halt), 32'd1);
    check("refire_cause", 32'(halt_cause), 32'd2);
    tick();

    // Clear slot 0 while in BREAK; slot 2 should then win
    bp_wr_en = 1'b1; bp_wr_idx = 2'd0; bp_wr_valid = 1'b0;
    tick();
    bp_wr_en = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0; pc_curr = 8'h11;
    tick();
    pc_curr = 8'h10;
    sample();
    check("bp2_halt", 32'(halt), 32'd1);
    check("bp2_idx", 32'(bp_hit_idx), 32'd2);
    tick();
    sample();
    check("bp2_brk_idx", 32'(bp_hit_idx), 32'd2);

    // Reset together with resume while in BREAK
    reset = 1'b1; resume = 1'b1;
    tick();
    reset = 1'b0; resume = 1'b0;
    sample();
    check("rst2_halt", 32'(halt), 32'd1);
    check("rst2_cause", 32'(halt_cause), 32'd0);
    check("rst2_bpidx", 32'(bp_hit_idx), 32'd0);
    check("rst2_cycle", 32'(cycle_count), 32'd0);
    pc_end = 8'h30; start = 1'b1; pc_curr = 8'h10;
    tick();
    start = 1'b0;
    sample();
    check("rst2_slots_clear", 32'(halt), 32'd0);
    pc_curr = 8'h30;
    sample();
    check("rst2_end_halt", 32'(halt), 32'd1);
    tick();

    // END beats BP on the same PC; resume ignored in DONE
    bp_wr_en = 1'b1; bp_wr_idx = 2'd1; bp_wr_addr = 8'h10; bp_wr_valid = 1'b1;
    tick();
    bp_wr_en = 1'b0;
    pc_end = 8'h10; start = 1'b1; pc_curr = 8'h10;
    tick();
    start = 1'b0;
    sample();
    check("prio_halt", 32'(halt), 32'd1);
    check("prio_cause", 32'(halt_cause), 32'd1);
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    sample();
    check("done_resume_halt", 32'(halt), 32'd1);
    check("done_resume_cause", 32'(halt_cause), 32'd1);

    // Timeout after 5 counted cycles
    timeout_limit = 16'd5; pc_end = 8'hFF; pc_curr = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("to_run_halt", 32'(halt), 32'd0);
      tick();
    end
    sample();
    check("to_halt", 32'(halt), 32'd1);
    check("to_cause", 32'(halt_cause), 32'd3);
    check("to_cycle", 32'(cycle_count), 32'd5);
    tick();
    sample();
    check("to_done_cause", 32'(halt_cause), 32'd3);
    check("to_done_cycle", 32'(cycle_count), 32'd5);

    // start while running must not reload end_pc
    timeout_limit = 16'd0; pc_end = 8'h50; pc_curr = 8'h40; start = 1'b1;
    tick();
    pc_end = 8'h60;
    tick();
    start = 1'b0; pc_curr = 8'h50;
    sample();
    check("rerun_end_halt", 32'(halt), 32'd1);
    check("rerun_end_cause", 32'(halt_cause), 32'd1);
    tick();

    // Out-of-range slot indices on the 5-slot instance are dropped
    bp_wr_en5 = 1'b1; bp_wr_addr = 8'h40; bp_wr_valid = 1'b1; bp_wr_idx5 = 3'd5;
    tick();
    bp_wr_idx5 = 3'd7;
    tick();
    bp_wr_idx5 = 3'd4; bp_wr_addr = 8'h41;
    tick();
    bp_wr_en5 = 1'b0;
    pc_end = 8'h90; start = 1'b1; pc_curr = 8'h40;
    tick();
    start = 1'b0;
    sample();
    check("oor_idx_nohalt", 32'(halt5), 32'd0);
    pc_curr = 8'h41;
    sample();
    check("slot4_halt", 32'(halt5), 32'd1);
    check("slot4_cause", 32'(halt_cause5), 32'd2);
    check("slot4_idx", 32'(bp_hit_idx5), 32'd4);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
